// File: rtl/pregrada_pkg.sv
// rtl/pregrada_pkg.sv - shared constants, state encoding and coil phase table for the barrier stepper
package pregrada_pkg;

  localparam int STEP_DELAY_DEF   = 200000;
  localparam int SWEEP_STEPS_DEF  = 200;
  localparam int DWELL_CYCLES_DEF = 25000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLOSE = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_OPEN  = 2'd3;

  localparam logic [3:0] MOTOR_OFF = 4'b0000;

  // Unipolar two-coils-on sequence; walking down the index closes, up reopens.
  function automatic logic [3:0] phase_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_pattern = 4'b1100;
      2'd1:    phase_pattern = 4'b0110;
      2'd2:    phase_pattern = 4'b0011;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_tick.sv
// rtl/step_tick.sv - step-rate prescaler; long_count lets the owner reuse the counter as a plain timer
module step_tick #(
  parameter int STEP_DELAY = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          long_count,
  output logic [CW-1:0] count,
  output logic          tick
);

  assign tick = !clear && !long_count && (count == CW'(STEP_DELAY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pregrada_stepper.sv
// rtl/pregrada_stepper.sv - barrier actuator: close/dwell/reopen sweep per reject, one reject queued
// Define PREGRADA_HOLD_EN to keep the home phase energised while idle.
module pregrada_stepper
  import pregrada_pkg::*;
#(
  parameter int STEP_DELAY   = STEP_DELAY_DEF,
  parameter int SWEEP_STEPS  = SWEEP_STEPS_DEF,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int PW           = $clog2(SWEEP_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reject_req,
  output logic          busy,
  output logic          done,
  output logic          drop,
  output logic [PW-1:0] position,
  output logic [3:0]    motor_pregrada
);

  localparam int TW = max_int(1, $clog2(max_int(STEP_DELAY, DWELL_CYCLES)));

  logic [1:0]    state;
  logic [1:0]    phase_idx;
  logic          pending;
  logic [PW-1:0] step_cnt;
  logic [TW-1:0] timer;
  logic          tick;
  logic          dwell_end;
  logic          last_step;
  logic          timer_clear;

  assign dwell_end   = (state == ST_DWELL) && (timer == TW'(DWELL_CYCLES - 1));
  assign last_step   = (step_cnt == PW'(SWEEP_STEPS - 1));
  assign timer_clear = (state == ST_IDLE) || dwell_end;

  step_tick #(
    .STEP_DELAY (STEP_DELAY),
    .CW         (TW)
  ) u_step_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (timer_clear),
    .long_count (state == ST_DWELL),
    .count      (timer),
    .tick       (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      phase_idx      <= 2'd0;
      pending        <= 1'b0;
      step_cnt       <= '0;
      position       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      drop           <= 1'b0;
      motor_pregrada <= MOTOR_OFF;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;

      // A strobe outside IDLE is queued once; a second one is discarded.
      if (reject_req && (state != ST_IDLE)) begin
        if (pending) begin
          drop <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          step_cnt <= '0;
          if (reject_req || pending) begin
            state   <= ST_CLOSE;
            busy    <= 1'b1;
            // A fresh strobe arriving while the queued one is consumed stays queued.
            pending <= pending && reject_req;
          end
        end

        ST_CLOSE: begin
          if (tick) begin
            phase_idx      <= phase_idx - 2'd1;
            motor_pregrada <= phase_pattern(phase_idx - 2'd1);
            if (position != PW'(SWEEP_STEPS)) begin
              position <= position + 1'b1;
            end
            if (last_step) begin
              step_cnt <= '0;
              state    <= ST_DWELL;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        ST_DWELL: begin
          if (dwell_end) begin
            state <= ST_OPEN;
          end
        end

        ST_OPEN: begin
          if (tick) begin
            phase_idx      <= phase_idx + 2'd1;
            motor_pregrada <= phase_pattern(phase_idx + 2'd1);
            if (position != '0) begin
              position <= position - 1'b1;
            end
            if (last_step) begin
              step_cnt <= '0;
              state    <= ST_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifndef PREGRADA_HOLD_EN
              // Coils drop out as the barrier reaches home so IDLE never holds torque.
              motor_pregrada <= MOTOR_OFF;
`endif
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pregrada_stepper.sv
// tb/tb_pregrada_stepper.sv - directed self-checking bench for pregrada_stepper
module tb_pregrada_stepper;

  localparam int SD = 4;
  localparam int SS = 3;
  localparam int DC = 5;
  localparam int PW = $clog2(SS + 1);
`ifdef PREGRADA_HOLD_EN
  localparam logic [3:0] HOME_MOTOR = 4'b1100;
`else
  localparam logic [3:0] HOME_MOTOR = 4'b0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reject_req = 1'b0;
  logic          busy;
  logic          done;
  logic          drop;
  logic [PW-1:0] position;
  logic [3:0]    motor_pregrada;

  pregrada_stepper #(
    .STEP_DELAY   (SD),
    .SWEEP_STEPS  (SS),
    .DWELL_CYCLES (DC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reject_req     (reject_req),
    .busy           (busy),
    .done           (done),
    .drop           (drop),
    .position       (position),
    .motor_pregrada (motor_pregrada)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc, busy_cnt, done_cnt, drop_cnt, gap_cnt, last_gap, low_run, fall_idx, done_idx;
  logic busy_prev, seen_busy;
  logic [3:0]    mprev;
  logic [PW-1:0] pprev;
  logic [3:0]    mlog[$];
  int            plog[$];

  logic [3:0] exp_motor[6];
  int         exp_pos[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
    gap_cnt = 0; last_gap = -1; low_run = 0; fall_idx = -1; done_idx = -1;
    busy_prev = busy; seen_busy = busy;
    mprev = motor_pregrada; pprev = position;
    mlog.delete(); plog.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_idx = cyc; end
    if (drop) drop_cnt++;
    if (!busy && seen_busy) low_run++;
    if (busy && low_run > 0) begin gap_cnt++; last_gap = low_run; low_run = 0; end
    if (busy) seen_busy = 1'b1;
    if (busy_prev && !busy) fall_idx = cyc;
    busy_prev = busy;
    if (motor_pregrada != mprev) begin mlog.push_back(motor_pregrada); mprev = motor_pregrada; end
    if (position != pprev) begin plog.push_back(int'(position)); pprev = position; end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    reject_req = 1'b1;
    step();
    reject_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    int waited;
    exp_motor = '{4'b1001, 4'b0011, 4'b0110, 4'b0011, 4'b1001, HOME_MOTOR};
    exp_pos   = '{1, 2, 3, 2, 1, 0};

    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop, 0);
    check("rst_pos", position, 0);
    check("rst_motor", motor_pregrada, 4'b0000);

    // Single reject: 2*3*4+5 busy cycles, done on the first low cycle.
    clear_stats();
    pulse();
    cycles(34);
    check("s1_busy_cycles", busy_cnt, 29);
    check("s1_done_cnt", done_cnt, 1);
    check("s1_drop_cnt", drop_cnt, 0);
    check("s1_done_at_fall", done_idx, 30);
    check("s1_fall_idx", fall_idx, 30);
    check("s1_motor_len", mlog.size(), 6);
    check("s1_pos_len", plog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_motor%0d", i), (i < mlog.size()) ? 32'(mlog[i]) : 32'hdead, 32'(exp_motor[i]));
      check($sformatf("s1_pos%0d", i), (i < plog.size()) ? plog[i] : 32'hdead, exp_pos[i]);
    end
    check("s1_idle_motor", motor_pregrada, HOME_MOTOR);

    // Queued reject during DWELL.
    do_reset();
    clear_stats();
    pulse();
    cycles(14);
    pulse();
    cycles(70);
    check("s2_busy_cycles", busy_cnt, 58);
    check("s2_done_cnt", done_cnt, 2);
    check("s2_gap_cnt", gap_cnt, 1);
    check("s2_gap_len", last_gap, 1);
    check("s2_drop_cnt", drop_cnt, 0);

    // Overflow: three strobes in one sweep.
    do_reset();
    clear_stats();
    pulse();
    cycles(3);
    pulse();
    cycles(3);
    pulse();
    cycles(70);
    check("s3_drop_cnt", drop_cnt, 1);
    check("s3_done_cnt", done_cnt, 2);
    check("s3_busy_cycles", busy_cnt, 58);

    // Strobe on the cycle of the final OPEN tick.
    do_reset();
    clear_stats();
    pulse();
    cycles(27);
    pulse();
    cycles(60);
    check("s4_drop_cnt", drop_cnt, 0);
    check("s4_done_cnt", done_cnt, 2);
    check("s4_busy_cycles", busy_cnt, 58);
    check("s4_gap_len", last_gap, 1);

    // Reset mid-CLOSE with a reject queued.
    do_reset();
    clear_stats();
    pulse();
    cycles(2);
    pulse();
    waited = 0;
    while (position != 2 && waited < 20) begin
      step();
      waited++;
    end
    check("s5_reached_pos2", position, 2);
    rst_n = 1'b0;
    #1;
    check("s5_rst_motor", motor_pregrada, 4'b0000);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_pos", position, 0);
    cycles(2);
    rst_n = 1'b1;
    clear_stats();
    cycles(40);
    check("s5_no_pending_busy", busy_cnt, 0);
    check("s5_no_pending_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
